// File: rtl/chan_blk_fifo_pkg.sv
// Shared definitions for the per-channel block FIFO and its arbitter.
//   CHAN_AW / CHAN_DW : default address and word widths (2048 x 16)
//   CHAN_MAXBLK       : largest legal block in words; sets the blk_ok threshold
//   CHAN_NCHAN        : number of channels (one FIFO instance each)
//   wr_act_t          : what the write side does in a given cycle
//   wr_decode()       : priority decode of the write-side controls
package chan_blk_fifo_pkg;

  localparam int CHAN_AW     = 11;
  localparam int CHAN_DW     = 16;
  localparam int CHAN_MAXBLK = 512;
  localparam int CHAN_NCHAN  = 16;

  // WR_DROP    : write attempted while full; word dropped and the block rolled back
  // WR_ROLLBACK: builder abort; uncommitted words discarded
  // WR_PUSH    : word stored, write pointer advances
  typedef enum logic [1:0] {
    WR_IDLE     = 2'd0,
    WR_PUSH     = 2'd1,
    WR_DROP     = 2'd2,
    WR_ROLLBACK = 2'd3
  } wr_act_t;

  // A full-drop outranks an explicit abort so that overflow is still flagged
  // when both happen together; either way the pointer returns to commit_addr.
  function automatic wr_act_t wr_decode(input logic wr_en,
                                        input logic full,
                                        input logic wr_abort);
    wr_act_t act;
    act = WR_IDLE;
    if (wr_en && full) begin
      act = WR_DROP;
    end else if (wr_abort) begin
      act = WR_ROLLBACK;
    end else if (wr_en) begin
      act = WR_PUSH;
    end
    return act;
  endfunction

endpackage

// File: rtl/chan_blk_fifo_if.sv
// Bus between one channel FIFO, its block builder and the arbitter.
//   Builder side : wr_data, wr_en, wr_commit, wr_abort -> FIFO; blk_ok, overflow <- FIFO
//   Arbitter side: dout, req <- FIFO; ack -> FIFO
// Modports: slave = the FIFO, master = builder + arbitter (or a testbench).
//
// Read handshake: req is high whenever at least one committed word is unread.
// A cycle with ack && req consumes exactly one word (rd_addr advances at the
// clock edge); ack while req is low is ignored. dout is a registered read of
// the current read address, so it shows the word at a new rd_addr one clock
// after rd_addr changes; the arbitter accounts for that lag.
interface chan_blk_fifo_if
  import chan_blk_fifo_pkg::*;
#(
  parameter int DW = CHAN_DW
) ();

  logic [DW-1:0] wr_data;
  logic          wr_en;
  logic          wr_commit;
  logic          wr_abort;
  logic          blk_ok;
  logic          overflow;
  logic [DW-1:0] dout;
  logic          req;
  logic          ack;

  modport master (
    output wr_data, wr_en, wr_commit, wr_abort, ack,
    input  blk_ok, overflow, dout, req
  );

  modport slave (
    input  wr_data, wr_en, wr_commit, wr_abort, ack,
    output blk_ok, overflow, dout, req
  );

endinterface

// File: rtl/chan_blk_fifo_ram.sv
// Simple dual-port RAM backing one channel FIFO.
//   clk   : clock, all on posedge
//   rst   : synchronous reset of the read data register only (array untouched)
//   we    : write wdata at waddr
//   raddr : read address; rdata <= mem[raddr] every clock (read-old on collision)
// Written as a plain array with a registered read so it maps onto block RAM.
module chan_blk_fifo_ram
  import chan_blk_fifo_pkg::*;
#(
  parameter int AW = CHAN_AW,
  parameter int DW = CHAN_DW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [0:(1<<AW)-1];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Output register reset is the only reset in here; contents stay as they were.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata <= '0;
    end else begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/chan_blk_fifo.sv
// Per-channel block FIFO sitting directly upstream of the arbitter.
// Words from the block builder only become visible to the arbitter once the
// whole block has been committed, so the arbitter never sees a partial block.
//   clk   : system clock
//   reset : synchronous, active-high
//   bus   : chan_blk_fifo_if.slave
//           wr_data/wr_en     word from builder, stored at wr_addr
//           wr_commit         end of block, publishes wr_addr (incl. same-cycle write)
//           wr_abort          discard the block in progress
//           blk_ok            free words >= MAXBLK (registered, one clock behind)
//           overflow          sticky: a write hit a full FIFO
//           dout/req/ack      arbitter read handshake
//
// Pointer roles (all AW bits, wrap naturally):
//   wr_addr     next slot the builder writes
//   commit_addr end of the last committed block
//   pub_addr    commit_addr delayed one clock; this is what the reader sees
//   rd_addr     next word to hand to the arbitter
// One slot is always left empty so wr_addr == rd_addr means "nothing written".
module chan_blk_fifo
  import chan_blk_fifo_pkg::*;
#(
  parameter int AW     = CHAN_AW,
  parameter int DW     = CHAN_DW,
  parameter int MAXBLK = CHAN_MAXBLK
) (
  input  logic             clk,
  input  logic             reset,
  chan_blk_fifo_if.slave   bus
);

  // MAXBLK must stay below 2**AW for this compare to mean anything.
  localparam logic [AW-1:0] MAXBLK_W = AW'(MAXBLK);
  localparam logic [AW-1:0] ONE      = AW'(1);

  logic [AW-1:0] wr_addr;
  logic [AW-1:0] commit_addr;
  logic [AW-1:0] pub_addr;
  logic [AW-1:0] rd_addr;

  logic [AW-1:0] wr_addr_inc;
  logic [AW-1:0] wr_addr_next;
  logic [AW-1:0] commit_addr_next;
  logic [AW-1:0] free_words;
  logic          full;
  logic          ram_we;
  logic          rd_fire;
  logic          req_int;
  logic          overflow_q;
  logic          blk_ok_q;
  logic [DW-1:0] dout_q;
  wr_act_t       wr_act;

  // ---------------------------------------------------------------------------
  // Write side and commit decode
  // ---------------------------------------------------------------------------
  always_comb begin
    wr_addr_inc      = wr_addr + ONE;
    full             = (wr_addr_inc == rd_addr);
    wr_act           = wr_decode(bus.wr_en, full, bus.wr_abort);
    wr_addr_next     = wr_addr;
    ram_we           = 1'b0;
    commit_addr_next = commit_addr;

    case (wr_act)
      WR_PUSH: begin
        wr_addr_next = wr_addr_inc;
        ram_we       = 1'b1;
      end
      // Both a full-drop and an abort rewind to the last commit point, so a
      // block that lost a word is never published.
      WR_DROP, WR_ROLLBACK: begin
        wr_addr_next = commit_addr;
      end
      default: begin
      end
    endcase

    // Commit publishes the post-write pointer. With abort (or a drop) the
    // pointer has already rewound to commit_addr, so the commit is a no-op,
    // exactly like committing an empty block.
    if (bus.wr_commit && !bus.wr_abort) begin
      commit_addr_next = wr_addr_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Read side and flags
  // ---------------------------------------------------------------------------
  always_comb begin
    req_int    = (rd_addr != pub_addr);
    rd_fire    = bus.ack && req_int;
    // Uncommitted words count as used: free is measured against wr_addr.
    free_words = rd_addr - wr_addr - ONE;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_addr     <= '0;
      commit_addr <= '0;
      pub_addr    <= '0;
      rd_addr     <= '0;
      overflow_q  <= 1'b0;
      blk_ok_q    <= 1'b1;
    end else begin
      wr_addr     <= wr_addr_next;
      commit_addr <= commit_addr_next;
      // Extra stage so a word's RAM write has landed before the reader can
      // address it; req therefore rises two edges after wr_commit is seen.
      pub_addr    <= commit_addr;
      if (rd_fire) begin
        rd_addr <= rd_addr + ONE;
      end
      if (wr_act == WR_DROP) begin
        overflow_q <= 1'b1;
      end
      blk_ok_q <= (free_words >= MAXBLK_W);
    end
  end

  // ---------------------------------------------------------------------------
  // Storage
  // ---------------------------------------------------------------------------
  chan_blk_fifo_ram #(
    .AW (AW),
    .DW (DW)
  ) u_ram (
    .clk   (clk),
    .rst   (reset),
    .we    (ram_we),
    .waddr (wr_addr),
    .wdata (bus.wr_data),
    .raddr (rd_addr),
    .rdata (dout_q)
  );

  assign bus.req      = req_int;
  assign bus.dout     = dout_q;
  assign bus.blk_ok   = blk_ok_q;
  assign bus.overflow = overflow_q;

endmodule

// File: tb/tb_chan_blk_fifo.sv
module tb_chan_blk_fifo;
  import chan_blk_fifo_pkg::*;

  localparam int AW = CHAN_AW;
  localparam int DW = CHAN_DW;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  chan_blk_fifo_if #(.DW(DW)) bus ();

  chan_blk_fifo #(
    .AW     (AW),
    .DW     (DW),
    .MAXBLK (CHAN_MAXBLK)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  logic [DW-1:0] exp_q[$];

  // ---------------------------------------------------------------------------
  // Vector table
  // ---------------------------------------------------------------------------
  typedef struct {
    logic          wr_en;
    logic [DW-1:0] wr_data;
    logic          wr_commit;
    logic          wr_abort;
    logic          ack;
    logic          exp_req;
    logic          exp_blk_ok;
    logic          exp_ovf;
    logic          chk_dout;
    logic [DW-1:0] exp_dout;
  } vec_t;

  vec_t vecs[$];

  task automatic add_vec(input logic we, input int d, input logic c, input logic a,
                         input logic k, input logic er, input logic cd, input int ed);
    vec_t v;
    v.wr_en      = we;
    v.wr_data    = DW'(d);
    v.wr_commit  = c;
    v.wr_abort   = a;
    v.ack        = k;
    v.exp_req    = er;
    v.exp_blk_ok = 1'b1;
    v.exp_ovf    = 1'b0;
    v.chk_dout   = cd;
    v.exp_dout   = DW'(ed);
    vecs.push_back(v);
  endtask

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic drive(input logic we, input logic [DW-1:0] d, input logic c,
                       input logic a, input logic k);
    bus.wr_en     = we;
    bus.wr_data   = d;
    bus.wr_commit = c;
    bus.wr_abort  = a;
    bus.ack       = k;
  endtask

  // Inputs set before step() are sampled at its posedge; outputs are read 1ns after.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
    step();
    step();
    reset = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  logic [AW-1:0] m_rd;
  logic [AW-1:0] m_wr;
  logic [AW-1:0] m_free;
  logic [DW-1:0] wd;
  int            cnt;
  int            cyc;
  int            words_written;
  int            blk_cnt;
  bit            in_blk;
  logic          we_s;
  logic          c_s;
  logic          k_s;
  logic          fire;

  initial begin
    reset = 1'b1;
    drive(1'b0, '0, 1'b0, 1'b0, 1'b0);

    // Table: 10 words uncommitted, commit latency, ack stream, abort+commit,
    // commit including same-cycle write, ignored ack, empty commit.
    for (int i = 0; i < 10; i++) add_vec(1, i, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 20; i++) add_vec(0, 0, 0, 0, 0, 0, 1, 0);
    add_vec(0, 0, 1, 0, 0, 0, 1, 0);            // commit edge: req still 0
    add_vec(0, 0, 0, 0, 1, 1, 1, 0);            // req rises; ack ignored (req was 0)
    for (int j = 0; j < 10; j++) add_vec(0, 0, 0, 0, 1, (j != 9), 1, j);
    for (int j = 0; j < 5; j++) add_vec(1, 100 + j, 0, 0, 0, 0, 0, 0);
    add_vec(0, 0, 1, 1, 0, 0, 0, 0);            // commit+abort: abort wins
    for (int j = 0; j < 3; j++) add_vec(0, 0, 0, 0, 0, 0, 0, 0);
    add_vec(1, 200, 0, 0, 0, 0, 0, 0);
    add_vec(1, 201, 0, 0, 0, 0, 0, 0);
    add_vec(1, 202, 1, 0, 0, 0, 0, 0);          // commit with same-cycle write
    add_vec(0, 0, 0, 0, 0, 1, 1, 200);
    for (int j = 0; j < 3; j++) add_vec(0, 0, 0, 0, 1, (j != 2), 1, 200 + j);
    add_vec(0, 0, 0, 0, 1, 0, 0, 0);            // ack with req low: ignored
    add_vec(0, 0, 1, 0, 0, 0, 0, 0);            // empty commit
    add_vec(0, 0, 0, 0, 0, 0, 0, 0);
    add_vec(0, 0, 0, 0, 0, 0, 0, 0);

    // Reset state
    step();
    step();
    check("reset req", 32'(bus.req), 32'd0);
    check("reset dout", 32'(bus.dout), 32'd0);
    check("reset overflow", 32'(bus.overflow), 32'd0);
    check("reset blk_ok", 32'(bus.blk_ok), 32'd1);
    reset = 1'b0;

    foreach (vecs[i]) begin
      drive(vecs[i].wr_en, vecs[i].wr_data, vecs[i].wr_commit, vecs[i].wr_abort, vecs[i].ack);
      step();
      check($sformatf("vec%0d req", i), 32'(bus.req), 32'(vecs[i].exp_req));
      check($sformatf("vec%0d blk_ok", i), 32'(bus.blk_ok), 32'(vecs[i].exp_blk_ok));
      check($sformatf("vec%0d overflow", i), 32'(bus.overflow), 32'(vecs[i].exp_ovf));
      if (vecs[i].chk_dout) begin
        check($sformatf("vec%0d dout", i), 32'(bus.dout), 32'(vecs[i].exp_dout));
      end
    end
    drive(1'b0, '0, 1'b0, 1'b0, 1'b0);

    // Fill 2047 words, commit every 256, then a write while full.
    do_reset();
    for (int i = 0; i < 2047; i++) begin
      drive(1'b1, DW'(i), (((i + 1) % 256) == 0), 1'b0, 1'b0);
      step();
      check($sformatf("fill%0d blk_ok", i), 32'(bus.blk_ok), 32'((2047 - i) >= 512));
      check($sformatf("fill%0d overflow", i), 32'(bus.overflow), 32'd0);
    end
    drive(1'b1, 16'hDEAD, 1'b0, 1'b0, 1'b0);
    step();
    check("full drop overflow", 32'(bus.overflow), 32'd1);
    check("full drop blk_ok", 32'(bus.blk_ok), 32'd0);
    drive(1'b0, '0, 1'b1, 1'b0, 1'b0);          // empty commit after rollback
    step();
    drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
    step();
    check("overflow sticky", 32'(bus.overflow), 32'd1);

    // Drain: only the 1792 committed words come out; blk_ok recovers at free=512.
    m_rd = '0;
    m_wr = AW'(1792);
    cnt  = 0;
    cyc  = 0;
    while (bus.req && cyc < 4000) begin
      m_free = m_rd - m_wr - AW'(1);
      drive(1'b0, '0, 1'b0, 1'b0, 1'b1);
      step();
      check($sformatf("drain%0d dout", cnt), 32'(bus.dout), 32'(cnt[DW-1:0]));
      check($sformatf("drain%0d blk_ok", cnt), 32'(bus.blk_ok), 32'(m_free >= AW'(CHAN_MAXBLK)));
      cnt++;
      cyc++;
      m_rd = m_rd + AW'(1);
    end
    drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
    check("drain count", 32'(cnt), 32'd1792);
    check("drain req", 32'(bus.req), 32'd0);

    // Wrap stream: 5000 words in 100-word blocks, random ack, crosses 2047->0.
    words_written = 0;
    blk_cnt       = 0;
    in_blk        = 1'b0;
    cyc           = 0;
    while ((words_written < 5000 || exp_q.size() != 0) && cyc < 60000) begin
      we_s = 1'b0;
      c_s  = 1'b0;
      wd   = '0;
      if (!in_blk && words_written < 5000 && bus.blk_ok) begin
        in_blk  = 1'b1;
        blk_cnt = 0;
      end
      if (in_blk) begin
        we_s = 1'b1;
        wd   = DW'($urandom_range(0, 65535));
        blk_cnt++;
        words_written++;
        exp_q.push_back(wd);
        if (blk_cnt == 100) begin
          c_s    = 1'b1;
          in_blk = 1'b0;
        end
      end
      k_s  = (words_written >= 5000) ? 1'b1 : ($urandom_range(0, 2) == 0);
      fire = k_s && bus.req;
      drive(we_s, wd, c_s, 1'b0, k_s);
      step();
      cyc++;
      if (fire) begin
        if (exp_q.size() == 0) begin
          check("stream unexpected read", 32'd1, 32'd0);
        end else begin
          check("stream dout", 32'(bus.dout), 32'(exp_q.pop_front()));
        end
      end
    end
    drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
    check("stream finished in budget", 32'(cyc < 60000), 32'd1);
    check("stream queue empty", 32'(exp_q.size()), 32'd0);
    step();
    check("stream req idle", 32'(bus.req), 32'd0);
    check("stream overflow still sticky", 32'(bus.overflow), 32'd1);

    // Reset mid-block: 4 committed unread words, 7 uncommitted words.
    for (int j = 0; j < 4; j++) begin
      drive(1'b1, DW'(16'h7000 + j), (j == 3), 1'b0, 1'b0);
      step();
    end
    drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
    step();
    check("midblk req before", 32'(bus.req), 32'd1);
    for (int j = 0; j < 7; j++) begin
      drive(1'b1, DW'(16'h7100 + j), 1'b0, 1'b0, 1'b0);
      step();
    end
    drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
    check("midblk dout before", 32'(bus.dout), 32'h7000);
    reset = 1'b1;
    step();
    check("midblk reset req", 32'(bus.req), 32'd0);
    check("midblk reset dout", 32'(bus.dout), 32'd0);
    check("midblk reset overflow", 32'(bus.overflow), 32'd0);
    check("midblk reset blk_ok", 32'(bus.blk_ok), 32'd1);
    reset = 1'b0;
    for (int j = 0; j < 4; j++) begin
      step();
      check($sformatf("post reset req%0d", j), 32'(bus.req), 32'd0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
